// File: rtl/gray_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gray_rd_arbiter                                              |
// | Description : Two-engine round-robin arbiter for the gray-image read port, |
// |               with bounded burst lock, tagged data return and finish join. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module gray_rd_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_lock,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              r0_finish,
    input  logic              r1_finish,
    output logic              finish
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    localparam logic [1:0] c_ST_WAIT_READY = 2'd0;
    localparam logic [1:0] c_ST_RUN        = 2'd1;
    localparam logic [1:0] c_ST_LOCKED     = 2'd2;
    localparam logic [1:0] c_ST_DONE       = 2'd3;

    localparam logic [CNT_W-1:0] c_BURST_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_done0;
    logic              r_done1;
    logic              r_tag;
    logic [ADDR_W-1:0] r_gray_addr;
    logic              r_gray_req;
    logic              r_r0_rvalid;
    logic              r_r1_rvalid;
    logic [DATA_W-1:0] r_r0_rdata;
    logic [DATA_W-1:0] r_r1_rdata;

    logic [1:0]        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [1:0]        w_gnt;
    logic [1:0]        w_req;
    logic [1:0]        w_lock;
    logic              w_done0_nxt;
    logic              w_done1_nxt;
    logic              w_sel_lock;

    assign w_req  = {r1_req, r0_req};
    assign w_lock = {r1_lock, r0_lock};

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_gnt       = 2'b00;
        w_sel_lock  = 1'b0;

        case (r_state)
            c_ST_WAIT_READY: begin
                if (gray_ready) begin
                    w_state_nxt = c_ST_RUN;
                end
            end

            c_ST_RUN: begin
                // On a tie the pointer picks the winner.
                if (r0_req && (!r1_req || !r_ptr)) begin
                    w_gnt[0] = 1'b1;
                end else if (r1_req) begin
                    w_gnt[1] = 1'b1;
                end
                if (w_gnt != 2'b00) begin
                    w_sel_lock = w_gnt[1] ? r1_lock : r0_lock;
                    if (w_sel_lock) begin
                        w_state_nxt = c_ST_LOCKED;
                        w_owner_nxt = w_gnt[1];
                        w_count_nxt = c_CNT_ONE;
                    end else begin
                        w_ptr_nxt = ~w_gnt[1];
                    end
                end
            end

            c_ST_LOCKED: begin
                if ((r_count == c_BURST_MAX) && w_req[~r_owner]) begin
                    // Burst exhausted with the other engine waiting: hand over.
                    w_gnt[~r_owner] = 1'b1;
                    w_ptr_nxt       = r_owner;
                    if (w_lock[~r_owner]) begin
                        w_owner_nxt = ~r_owner;
                        w_count_nxt = c_CNT_ONE;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                        w_count_nxt = '0;
                    end
                end else if (w_req[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    if (w_lock[r_owner]) begin
                        w_count_nxt = (r_count == c_BURST_MAX) ? c_CNT_ONE
                                                               : r_count + c_CNT_ONE;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                        w_ptr_nxt   = ~r_owner;
                        w_count_nxt = '0;
                    end
                end else begin
                    w_state_nxt = c_ST_RUN;
                    w_ptr_nxt   = ~r_owner;
                    w_count_nxt = '0;
                end
            end

            default: begin
            end
        endcase

        w_done0_nxt = r_done0 | (r0_finish && (r_state != c_ST_WAIT_READY));
        w_done1_nxt = r_done1 | (r1_finish && (r_state != c_ST_WAIT_READY));
        if ((r_state != c_ST_WAIT_READY) && w_done0_nxt && w_done1_nxt) begin
            w_state_nxt = c_ST_DONE;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_WAIT_READY;
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_count     <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_tag       <= 1'b0;
            r_gray_addr <= '0;
            r_gray_req  <= 1'b0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_r0_rdata  <= '0;
            r_r1_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;

            if (w_gnt != 2'b00) begin
                r_gray_addr <= w_gnt[1] ? r1_addr : r0_addr;
                r_gray_req  <= 1'b1;
                r_tag       <= w_gnt[1];
            end else begin
                r_gray_req  <= 1'b0;
            end

            // Memory is combinational, so data for the driven address is ready now.
            r_r0_rvalid <= r_gray_req && !r_tag;
            r_r1_rvalid <= r_gray_req && r_tag;
            if (r_gray_req && !r_tag) begin
                r_r0_rdata <= gray_data;
            end
            if (r_gray_req && r_tag) begin
                r_r1_rdata <= gray_data;
            end
        end
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign gray_addr = r_gray_addr;
    assign gray_req  = r_gray_req;
    assign r0_rvalid = r_r0_rvalid;
    assign r1_rvalid = r_r1_rvalid;
    assign r0_rdata  = r_r0_rdata;
    assign r1_rdata  = r_r1_rdata;
    assign finish    = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
